// File: rtl/pipelined_addsub_n.sv
// Pipelined N-bit adder/subtractor. The carry chain is cut into STAGES ripple slices with a
// register after each slice. Stage k adds slice k of A and B' (B' = in_sub ? ~B : B) using the
// carry registered by stage k-1. Upper operand slices that have not been added yet travel down
// the pipe with their beat, and so do the finished lower sum slices.
// The handshake is a single global enable: every stage moves on "advance", or all stages hold.
module pipelined_addsub_n #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  // The guard keeps the division legal, so that the depth check below can report a bad depth.
  localparam int unsigned SLICE = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
  localparam int unsigned LAST  = (STAGES == 0) ? 0 : STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_depth
    $error("pipelined_addsub_n: STAGES must be in 1..WIDTH");
  end
  if (STAGES != 0 && (WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_addsub_n: WIDTH must be a multiple of STAGES");
  end

  logic advance;
  logic accept;
  logic [WIDTH-1:0] b_eff;

  // Index k of each *_in signal is what stage k consumes. Index 0 comes from the ports.
  // Index k+1 comes from the registers of stage k.
  logic [STAGES-1:0]            valid_in;
  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            carry_in;
  logic [STAGES-1:0]            carry_d;
  logic [STAGES-1:0]            carry_q;
  // x holds the unprocessed upper slices of A and the finished lower slices of the sum.
  logic [STAGES-1:0][WIDTH-1:0] x_in;
  logic [STAGES-1:0][WIDTH-1:0] x_d;
  logic [STAGES-1:0][WIDTH-1:0] x_q;
  logic [STAGES-1:0][WIDTH-1:0] y_in;
  logic                         ovf_d;
  logic                         ovf_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign b_eff    = in_sub ? ~in_b : in_b;

  assign valid_in[0] = accept;
  assign carry_in[0] = in_cin;
  assign x_in[0]     = in_a;
  assign y_in[0]     = b_eff;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LSB = k * SLICE;
    localparam logic [WIDTH-1:0] SLICE_MASK = ({WIDTH{1'b1}} >> (WIDTH - SLICE)) << LSB;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_res;

    assign a_slice   = SLICE'(x_in[k] >> LSB);
    assign b_slice   = SLICE'(y_in[k] >> LSB);
    assign slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_in[k]};

    // The sum slice overwrites the A slice it consumed. The other bits pass through unchanged.
    assign x_d[k]     = (x_in[k] & ~SLICE_MASK) | (WIDTH'(slice_res[SLICE-1:0]) << LSB);
    assign carry_d[k] = slice_res[SLICE];

    if (k < LAST) begin : g_fwd
      logic [WIDTH-1:0] y_q;

      // B' travels with its beat. The final stage has no later slice, so it needs no copy.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= '0;
        end else if (advance) begin
          y_q <= y_in[k];
        end
      end

      assign y_in[k+1]     = y_q;
      assign x_in[k+1]     = x_q[k];
      assign carry_in[k+1] = carry_q[k];
      assign valid_in[k+1] = valid_q[k];
    end
  end

  // Signed overflow: the operand signs agree and the sign of the sum differs from them.
  assign ovf_d = (x_in[LAST][WIDTH-1] == y_in[LAST][WIDTH-1]) &&
                 (x_d[LAST][WIDTH-1] != x_in[LAST][WIDTH-1]);

  // Pipe registers: all stages shift together on advance and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      x_q     <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
    end else if (advance) begin
      valid_q <= valid_in;
      x_q     <= x_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_sum   = x_q[LAST];
  assign out_cout  = carry_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub_n.sv
// Bench for pipelined_addsub_n. It checks the default 32/4 build with a stream scoreboard.
// It also checks the 8/2 and 16/1 builds with back-to-back beats.
module tb_pipelined_addsub_n;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [31:0] sum;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [31:0] out_sum;

  logic        s_valid, s_cin, s_sub;
  logic [15:0] s_a, s_b;
  logic        s8_ready, o8_valid, o8_cout, o8_ovf;
  logic [7:0]  o8_sum;
  logic        s16_ready, o16_valid, o16_cout, o16_ovf;
  logic [15:0] o16_sum;

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  beat_t send_q[$];
  res_t  got_q[$];
  int    acc_at[$];
  int    got_at[$];

  always #5 clk = ~clk;

  pipelined_addsub_n #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  pipelined_addsub_n #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s8_ready), .in_a(s_a[7:0]),
    .in_b(s_b[7:0]), .in_cin(s_cin), .in_sub(s_sub), .out_valid(o8_valid),
    .out_ready(1'b1), .out_sum(o8_sum), .out_cout(o8_cout), .out_ovf(o8_ovf)
  );

  pipelined_addsub_n #(.WIDTH(16), .STAGES(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s16_ready), .in_a(s_a),
    .in_b(s_b), .in_cin(s_cin), .in_sub(s_sub), .out_valid(o16_valid),
    .out_ready(1'b1), .out_sum(o16_sum), .out_cout(o16_cout), .out_ovf(o16_ovf)
  );

  function automatic beat_t mk(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    beat_t x;
    x.a = a; x.b = b; x.cin = cin; x.sub = sub;
    return x;
  endfunction

  // Reference model: unbounded integer arithmetic, then reduced to w bits.
  // Overflow is found from the signed range.
  function automatic res_t model(beat_t x, int w);
    longint unsigned mask, a, bp, full;
    longint sa, sb, s, lim;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    a    = 64'(x.a) & mask;
    bp   = (x.sub ? ~64'(x.b) : 64'(x.b)) & mask;
    full = a + bp + 64'(x.cin);
    lim  = longint'(64'd1 << (w - 1));
    sa   = (a >= 64'(lim)) ? longint'(a) - 2 * lim : longint'(a);
    sb   = (bp >= 64'(lim)) ? longint'(bp) - 2 * lim : longint'(bp);
    s    = sa + sb + longint'(x.cin);
    r.sum  = 32'(full & mask);
    r.cout = ((full >> w) & 64'd1) != 0;
    r.ovf  = (s >= lim) || (s < -lim);
    return r;
  endfunction

  task automatic clear_q();
    send_q.delete(); got_q.delete(); acc_at.delete(); got_at.delete();
  endtask

  // One cycle of the main DUT. Inputs are driven at the negedge and outputs are sampled
  // 1 time unit later. The handshakes that fire on the next posedge are then recorded.
  task automatic step(input bit rdy, input int vld_pct);
    @(negedge clk);
    out_ready = rdy;
    if (send_q.size() > 0 && int'($urandom_range(99)) < vld_pct) begin
      in_valid = 1'b1;
      in_a = send_q[0].a; in_b = send_q[0].b; in_cin = send_q[0].cin; in_sub = send_q[0].sub;
    end else begin
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_sub = 1'($urandom);
    end
    #1;
    if (out_valid && out_ready) begin
      got_q.push_back({out_ovf, out_cout, out_sum});
      got_at.push_back(step_no);
    end
    if (in_valid && in_ready) begin
      void'(send_q.pop_front());
      acc_at.push_back(step_no);
    end
    step_no++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if ({out_ovf, out_cout, out_sum} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {out_ovf, out_cout, out_sum});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({o8_valid, o16_valid} !== 2'b00) begin
      errors++; $display("FAIL reset_small_valid: got %b expected 00", {o8_valid, o16_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_latency();
    clear_q();
    send_q.push_back(mk(32'd5, 32'd9, 1'b0, 1'b0));
    for (int n = 0; n < 20 && got_q.size() == 0; n++) step(1'b1, 100);
    checks++;
    if (got_q.size() != 1 || acc_at.size() != 1) begin
      errors++; $display("FAIL add_timeout: got %0d results expected 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {1'b0, 1'b0, 32'd14}) begin
        errors++; $display("FAIL add_5_9: got %h expected %h", got_q[0], {2'b00, 32'd14});
      end
      checks++;
      if (got_at[0] - acc_at[0] != 4) begin
        errors++; $display("FAIL add_latency: got %0d expected 4", got_at[0] - acc_at[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_sum [3];
    exp_sum[0] = 32'd973288; exp_sum[1] = 32'd151250; exp_sum[2] = 32'd27435;
    clear_q();
    send_q.push_back(mk(32'd111124, 32'd862164, 1'b0, 1'b0));
    send_q.push_back(mk(32'd151241, 32'd9, 1'b0, 1'b0));
    send_q.push_back(mk(32'd24221, 32'd3214, 1'b0, 1'b0));
    for (int n = 0; n < 30 && got_q.size() < 3; n++) step(1'b1, 100);
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL b2b_count: got %0d expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== {2'b00, exp_sum[i]}) begin
          errors++; $display("FAIL b2b_sum[%0d]: got %h expected %h", i, got_q[i], exp_sum[i]);
        end
      end
      checks++;
      if (got_at[1] != got_at[0] + 1 || got_at[2] != got_at[0] + 2) begin
        errors++; $display("FAIL b2b_spacing: got steps %0d %0d %0d expected consecutive",
                           got_at[0], got_at[1], got_at[2]);
      end
    end
  endtask

  task automatic test_corners();
    res_t exp [4];
    clear_q();
    send_q.push_back(mk(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0));
    exp[0] = {1'b0, 1'b1, 32'h0};
    send_q.push_back(mk(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0));
    exp[1] = {1'b1, 1'b0, 32'h8000_0000};
    send_q.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0));
    exp[2] = {1'b1, 1'b1, 32'h0};
    send_q.push_back(mk(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0));
    exp[3] = {1'b0, 1'b1, 32'h0};
    for (int n = 0; n < 30 && got_q.size() < 4; n++) step(1'b1, 100);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL corner_count: got %0d expected 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp[i]) begin
          errors++; $display("FAIL corner[%0d]: got %h expected %h", i, got_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_sub();
    res_t exp [3];
    clear_q();
    send_q.push_back(mk(32'd5, 32'd9, 1'b1, 1'b1));
    exp[0] = {1'b0, 1'b0, 32'hFFFF_FFFC};
    send_q.push_back(mk(32'd9, 32'd5, 1'b1, 1'b1));
    exp[1] = {1'b0, 1'b1, 32'd4};
    send_q.push_back(mk(32'h8000_0000, 32'd1, 1'b1, 1'b1));
    exp[2] = {1'b1, 1'b1, 32'h7FFF_FFFF};
    for (int n = 0; n < 30 && got_q.size() < 3; n++) step(1'b1, 100);
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL sub_count: got %0d expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp[i]) begin
          errors++; $display("FAIL sub[%0d]: got %h expected %h", i, got_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    beat_t beats[$];
    res_t  hold;
    clear_q();
    for (int i = 0; i < 6; i++) beats.push_back(mk($urandom, $urandom, 1'($urandom), 1'($urandom)));
    send_q = beats;
    hold = model(beats[1], 32);
    for (int n = 0; n < 60 && got_q.size() < 6; n++) begin
      step(!(n >= 5 && n <= 7), 100);
      if (n >= 5 && n <= 7) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++; $display("FAIL bp_stall_flags step %0d: got ready=%b valid=%b expected 0 1",
                             n, in_ready, out_valid);
        end
        checks++;
        if ({out_ovf, out_cout, out_sum} !== hold) begin
          errors++; $display("FAIL bp_frozen step %0d: got %h expected %h", n,
                             {out_ovf, out_cout, out_sum}, hold);
        end
      end
    end
    repeat (5) step(1'b1, 100);
    checks++;
    if (got_q.size() != 6 || acc_at.size() != 6) begin
      errors++; $display("FAIL bp_count: got %0d results expected 6", got_q.size());
    end else begin
      checks++;
      if (acc_at[5] - acc_at[0] != 8) begin
        errors++; $display("FAIL bp_accept_delay: got %0d expected 8", acc_at[5] - acc_at[0]);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (got_q[i] !== model(beats[i], 32)) begin
          errors++; $display("FAIL bp_result[%0d]: got %h expected %h", i, got_q[i],
                             model(beats[i], 32));
        end
      end
    end
  endtask

  task automatic test_random();
    beat_t beats[$];
    logic [31:0] corner [4];
    logic [31:0] a, b;
    corner[0] = 32'hFFFF_FFFF; corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'h8000_0000; corner[3] = 32'h0;
    clear_q();
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(4) == 0) ? corner[$urandom_range(3)] : $urandom;
      b = ($urandom_range(4) == 0) ? corner[$urandom_range(3)] : $urandom;
      beats.push_back(mk(a, b, 1'($urandom), 1'($urandom)));
    end
    send_q = beats;
    for (int n = 0; n < 2000 && got_q.size() < 80; n++) step($urandom_range(9) < 7, 75);
    checks++;
    if (got_q.size() != 80) begin
      errors++; $display("FAIL rand_count: got %0d expected 80", got_q.size());
    end else begin
      for (int i = 0; i < 80; i++) begin
        checks++;
        if (got_q[i] !== model(beats[i], 32)) begin
          errors++; $display("FAIL rand_result[%0d]: got %h expected %h", i, got_q[i],
                             model(beats[i], 32));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_q();
    for (int i = 0; i < 4; i++) send_q.push_back(mk($urandom, $urandom, 1'b0, 1'b0));
    for (int n = 0; n < 5; n++) step(1'b1, 100);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {out_ovf, out_cout, out_sum} !== 34'd0) begin
      errors++; $display("FAIL mid_async_clear: got valid=%b data=%h expected 0 0",
                         out_valid, {out_ovf, out_cout, out_sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    send_q.push_back(mk(32'd1, 32'd1, 1'b0, 1'b0));
    for (int n = 0; n < 20 && got_q.size() == 0; n++) step(1'b1, 100);
    repeat (6) step(1'b1, 100);
    checks++;
    if (got_q.size() != 1 || acc_at.size() != 1) begin
      errors++; $display("FAIL mid_after_count: got %0d results expected 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {2'b00, 32'd2}) begin
        errors++; $display("FAIL mid_after_sum: got %h expected 2", got_q[0]);
      end
      checks++;
      if (got_at[0] - acc_at[0] != 4) begin
        errors++; $display("FAIL mid_after_latency: got %0d expected 4", got_at[0] - acc_at[0]);
      end
    end
  endtask

  task automatic test_small_configs();
    beat_t v[$];
    res_t  exp, obs;
    logic  obs_v, obs_rdy;
    int    w, lat;
    logic [31:0] ones, maxpos, minneg;
    in_valid = 1'b0;
    for (int cfg = 0; cfg < 2; cfg++) begin
      w      = (cfg == 0) ? 8 : 16;
      lat    = (cfg == 0) ? 2 : 1;
      ones   = (32'd1 << w) - 32'd1;
      maxpos = (32'd1 << (w - 1)) - 32'd1;
      minneg = 32'd1 << (w - 1);
      v.delete();
      v.push_back(mk(32'd5, 32'd9, 1'b0, 1'b0));
      v.push_back(mk(32'd111124, 32'd862164, 1'b0, 1'b0));
      v.push_back(mk(32'd151241, 32'd9, 1'b0, 1'b0));
      v.push_back(mk(32'd24221, 32'd3214, 1'b0, 1'b0));
      v.push_back(mk(ones, 32'd1, 1'b0, 1'b0));
      v.push_back(mk(maxpos, 32'd1, 1'b0, 1'b0));
      v.push_back(mk(32'd5, 32'd9, 1'b1, 1'b1));
      v.push_back(mk(32'd9, 32'd5, 1'b1, 1'b1));
      v.push_back(mk(minneg, 32'd1, 1'b1, 1'b1));
      for (int i = 0; i < 6; i++) v.push_back(mk($urandom, $urandom, 1'($urandom), 1'($urandom)));
      for (int n = 0; n < v.size() + lat; n++) begin
        @(negedge clk);
        if (n < v.size()) begin
          s_valid = 1'b1; s_a = v[n].a[15:0]; s_b = v[n].b[15:0];
          s_cin = v[n].cin; s_sub = v[n].sub;
        end else begin
          s_valid = 1'b0;
        end
        #1;
        if (n >= lat) begin
          exp = model(v[n-lat], w);
          if (cfg == 0) begin
            obs_v = o8_valid; obs_rdy = s8_ready; obs = {o8_ovf, o8_cout, 24'd0, o8_sum};
          end else begin
            obs_v = o16_valid; obs_rdy = s16_ready; obs = {o16_ovf, o16_cout, 16'd0, o16_sum};
          end
          checks++;
          if (obs_v !== 1'b1 || obs_rdy !== 1'b1 || obs !== exp) begin
            errors++; $display("FAIL small_w%0d[%0d]: got v=%b r=%b %h expected v=1 r=1 %h",
                               w, n - lat, obs_v, obs_rdy, obs, exp);
          end
        end
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_back_to_back();
    test_corners();
    test_sub();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_small_configs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
